// File: rtl/pcler8_pkg.sv
// pcler8 timer shared definitions: FSM states, register map, CTRL bits.
// Also holds the prescaler width helper used by the prescaler counter.
package pcler8_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_COUNT  = 2'd0;
   localparam logic [1:0] ADDR_RELOAD = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;

   localparam int CTRL_RUN     = 0;
   localparam int CTRL_ONESHOT = 1;
   localparam int CTRL_IRQEN   = 2;

   function automatic int presc_w(input int p);
      return (p > 1) ? $clog2(p) : 1;
   endfunction

endpackage

// File: rtl/pcler8_timer_ctrl_if.sv
// pcler8 timer register write port: wr_en strobe, 2-bit addr, 8-bit data.
// master drives the write, slave (the timer) receives it.
interface pcler8_timer_ctrl_if;

   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;

   modport master (output wr_en, output wr_addr, output wr_data);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/pcler8_prescaler.sv
// pcler8 prescaler: counts 0..PRESCALE-1 while en, tick on last value.
// Ports: clk, rst_n, en, clr (sync clear to 0), tick (comb out).
module pcler8_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);
   import pcler8_pkg::*;

   localparam int W = presc_w(PRESCALE);
   localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

   logic [W-1:0] presc;

   assign tick = en && (presc == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         presc <= '0;
      else if (clr || !en || tick)
         presc <= '0;
      else
         presc <= presc + 1'b1;
   end

endmodule

// File: rtl/pcler8_timer_ctrl.sv
// pcler8 8-bit up timer: count/reload regs, prescaler, IDLE/RUN/DONE FSM, irq.
// Ports: clk, rst_n, bus (write port), count, running, tc_pulse, irq,
// irq_ack, overrun (live only with PCLER8_OVERRUN_EN, else tied 0).
module pcler8_timer_ctrl #(
   parameter int         PRESCALE   = 4,
   parameter logic [7:0] RELOAD_RST = 8'h00
) (
   input  logic                     clk,
   input  logic                     rst_n,
   pcler8_timer_ctrl_if.slave       bus,
   output logic [7:0]               count,
   output logic                     running,
   output logic                     tc_pulse,
   output logic                     irq,
   input  logic                     irq_ack,
   output logic                     overrun
);
   import pcler8_pkg::*;

   state_t     state, nxt;
   logic [7:0] reload;
   logic [2:0] ctrl;
   logic       cnt_wr, rel_wr, ctrl_wr;
   logic       tick, eff_tick, tc;
   logic       leave_run, presc_clr;

   assign cnt_wr  = bus.wr_en && (bus.wr_addr == ADDR_COUNT);
   assign rel_wr  = bus.wr_en && (bus.wr_addr == ADDR_RELOAD);
   assign ctrl_wr = bus.wr_en && (bus.wr_addr == ADDR_CTRL);

   // a COUNT write swallows a coincident tick
   assign eff_tick = tick && !cnt_wr;
   assign tc       = eff_tick && (count == 8'hFF);

   assign leave_run = (state == RUN) && (nxt != RUN);
   assign presc_clr = leave_run || cnt_wr;
   assign running   = (state == RUN);

   pcler8_prescaler #(.PRESCALE(PRESCALE)) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (running),
      .clr   (presc_clr),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:
            if (ctrl_wr && bus.wr_data[CTRL_RUN])
               nxt = RUN;
         RUN:
            if (ctrl_wr && !bus.wr_data[CTRL_RUN])
               nxt = IDLE;
            else if (tc && ctrl[CTRL_ONESHOT])
               nxt = DONE;
         DONE:
            if (ctrl_wr)
               nxt = bus.wr_data[CTRL_RUN] ? RUN : IDLE;
         default:
            nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl <= '0;
      end else begin
         if (ctrl_wr)
            ctrl <= bus.wr_data[2:0];
         if ((state == RUN) && (nxt == DONE))
            ctrl[CTRL_RUN] <= 1'b0;
      end
   end

   // reload read here is the pre-write value on a coincident RELOAD write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 8'h00;
         reload <= RELOAD_RST;
      end else begin
         if (rel_wr)
            reload <= bus.wr_data;
         if (cnt_wr)
            count <= bus.wr_data;
         else if (tc)
            count <= reload;
         else if (eff_tick)
            count <= count + 8'h01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tc_pulse <= 1'b0;
         irq      <= 1'b0;
      end else begin
         tc_pulse <= tc;
         if (tc && ctrl[CTRL_IRQEN])
            irq <= 1'b1;
         else if (irq_ack)
            irq <= 1'b0;
      end
   end

`ifdef PCLER8_OVERRUN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overrun <= 1'b0;
      else if (tc && ctrl[CTRL_IRQEN] && irq && !irq_ack)
         overrun <= 1'b1;
      else if (irq_ack)
         overrun <= 1'b0;
   end
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_pcler8_timer_ctrl.sv
// pcler8 timer bench: directed writes, fixed-cycle steps, hand-computed values.
// dut_a uses PRESCALE=4, dut_b uses PRESCALE=1.
module tb_pcler8_timer_ctrl;

   logic       clk;
   logic       rst_n;
   logic       ack_a, ack_b;
   logic [7:0] cnt_a, cnt_b;
   logic       run_a, run_b;
   logic       tcp_a, tcp_b;
   logic       irq_a, irq_b;
   logic       ovr_a, ovr_b;

   int n_chk;
   int n_pass;

   pcler8_timer_ctrl_if ifa ();
   pcler8_timer_ctrl_if ifb ();

   pcler8_timer_ctrl #(.PRESCALE(4), .RELOAD_RST(8'h00)) dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (ifa),
      .count    (cnt_a),
      .running  (run_a),
      .tc_pulse (tcp_a),
      .irq      (irq_a),
      .irq_ack  (ack_a),
      .overrun  (ovr_a)
   );

   pcler8_timer_ctrl #(.PRESCALE(1), .RELOAD_RST(8'h00)) dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (ifb),
      .count    (cnt_b),
      .running  (run_b),
      .tc_pulse (tcp_b),
      .irq      (irq_b),
      .irq_ack  (ack_b),
      .overrun  (ovr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input bit b, input logic [1:0] a,
                     input logic [7:0] d);
      if (!b) begin
         ifa.wr_en = 1'b1; ifa.wr_addr = a; ifa.wr_data = d;
      end else begin
         ifb.wr_en = 1'b1; ifb.wr_addr = a; ifb.wr_data = d;
      end
      step(1);
      ifa.wr_en = 1'b0;
      ifb.wr_en = 1'b0;
   endtask

   task automatic ack_pulse();
      ack_a = 1'b1;
      step(1);
      ack_a = 1'b0;
   endtask

`ifdef PCLER8_OVERRUN_EN
   localparam logic OVR_EXP = 1'b1;
`else
   localparam logic OVR_EXP = 1'b0;
`endif

   initial begin
      n_chk = 0;
      n_pass = 0;
      rst_n = 1'b0;
      ack_a = 1'b0;
      ack_b = 1'b0;
      ifa.wr_en = 1'b0; ifa.wr_addr = 2'd0; ifa.wr_data = 8'h00;
      ifb.wr_en = 1'b0; ifb.wr_addr = 2'd0; ifb.wr_data = 8'h00;
      step(3);
      chk("rst_count", cnt_a, 8'h00);
      chk("rst_run", run_a, 1'b0);
      chk("rst_tc", tcp_a, 1'b0);
      chk("rst_irq", irq_a, 1'b0);
      chk("rst_ovr", ovr_a, 1'b0);
      rst_n = 1'b1;
      step(1);

      // basic run: FD -> FE -> FF -> reload 10
      wr(0, 2'd0, 8'hFD);
      wr(0, 2'd1, 8'h10);
      wr(0, 2'd2, 8'h05);
      chk("run_up", run_a, 1'b1);
      step(3);
      chk("pre_tick", cnt_a, 8'hFD);
      step(1);
      chk("tick1", cnt_a, 8'hFE);
      step(4);
      chk("tick2", cnt_a, 8'hFF);
      chk("no_tc_yet", tcp_a, 1'b0);
      step(4);
      chk("wrap", cnt_a, 8'h10);
      chk("tc_hi", tcp_a, 1'b1);
      chk("irq_set", irq_a, 1'b1);
      step(1);
      chk("tc_lo", tcp_a, 1'b0);
      chk("hold_after", cnt_a, 8'h10);

      // second TC with irq pending, no ack
      wr(0, 2'd0, 8'hFF);
      step(4);
      chk("tc2_cnt", cnt_a, 8'h10);
      chk("ovr_set", ovr_a, OVR_EXP);
      ack_pulse();
      chk("ack_irq", irq_a, 1'b0);
      chk("ack_ovr", ovr_a, 1'b0);

      // COUNT write lands on a tick edge
      wr(0, 2'd0, 8'h20);
      step(3);
      wr(0, 2'd0, 8'h30);
      chk("wr_wins", cnt_a, 8'h30);
      chk("wr_no_tc", tcp_a, 1'b0);
      step(3);
      chk("presc_rst", cnt_a, 8'h30);
      step(1);
      chk("presc_tick", cnt_a, 8'h31);

      // ack coincident with TC: set wins
      wr(0, 2'd0, 8'hFF);
      step(4);
      chk("irq_re", irq_a, 1'b1);
      wr(0, 2'd0, 8'hFF);
      step(3);
      ack_pulse();
      chk("ack_tc_irq", irq_a, 1'b1);
      chk("ack_tc_pulse", tcp_a, 1'b1);

      // oneshot, irq_en off
      wr(0, 2'd2, 8'h03);
      wr(0, 2'd0, 8'hFF);
      step(4);
      chk("os_cnt", cnt_a, 8'h10);
      chk("os_tc", tcp_a, 1'b1);
      chk("os_run", run_a, 1'b0);
      step(10);
      chk("os_frozen", cnt_a, 8'h10);
      chk("os_no_tc", tcp_a, 1'b0);
      chk("irq_kept", irq_a, 1'b1);

      // RELOAD write coincident with TC uses old reload
      wr(0, 2'd2, 8'h01);
      chk("done_run", run_a, 1'b1);
      wr(0, 2'd0, 8'hFF);
      step(3);
      wr(0, 2'd1, 8'h55);
      chk("old_reload", cnt_a, 8'h10);
      wr(0, 2'd0, 8'hFF);
      step(4);
      chk("new_reload", cnt_a, 8'h55);

      // async reset mid-run
      wr(0, 2'd0, 8'h42);
      step(1);
      chk("pre_rst", cnt_a, 8'h42);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_cnt", cnt_a, 8'h00);
      chk("arst_irq", irq_a, 1'b0);
      chk("arst_run", run_a, 1'b0);
      chk("arst_tc", tcp_a, 1'b0);
      step(1);
      rst_n = 1'b1;
      step(2);
      chk("idle_hold", cnt_a, 8'h00);

      // PRESCALE=1 dut: tick every cycle
      wr(1, 2'd0, 8'hFE);
      wr(1, 2'd1, 8'h80);
      wr(1, 2'd2, 8'h01);
      chk("p1_start", cnt_b, 8'hFE);
      step(1);
      chk("p1_ff", cnt_b, 8'hFF);
      chk("p1_tc0", tcp_b, 1'b0);
      step(1);
      chk("p1_wrap", cnt_b, 8'h80);
      chk("p1_tc1", tcp_b, 1'b1);
      step(1);
      chk("p1_next", cnt_b, 8'h81);
      chk("p1_tc2", tcp_b, 1'b0);
      chk("p1_noirq", irq_b, 1'b0);
      chk("p1_ovr", ovr_b, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
